bp_fe_bht_gshare: RTL
=====================

Name: bp_fe_bht_gshare

Overview:
Parametrised gshare branch history table for the front end. Counter width, table depth and global-history length are configurable. Prediction is a registered one-cycle lookup indexed by PC-index XOR global history. Adds what the flat BHT lacks: a speculative global history register with restore on redirect, a sequential post-reset clear sweep, and a taken/not-taken training interface. The predictor's hashed index is returned as metadata for later training.

Parameters:
bht_idx_width_p, 9, log2 of entry count; table has 2**bht_idx_width_p counters.
ghist_width_p, 8, global history length; legal range 1..bht_idx_width_p.
ctr_width_p, 2, saturating counter width; legal range 2..4.

Ports:
clk_i  in  1  clock; all state changes on posedge.
reset_n_i  in  1  asynchronous active-low reset.
en_i  in  1  global enable; when low, all state and outputs hold, including the clear sweep.
init_done_o  out  1  high once the clear sweep has completed.
r_v_i  in  1  prediction request.
r_idx_i  in  bht_idx_width_p  PC-derived index.
predict_v_o  out  1  prediction valid, one cycle after an accepted r_v_i.
predict_taken_o  out  1  MSB of the selected counter.
predict_idx_o  out  bht_idx_width_p  hashed index used; returned later on w_idx_i.
predict_ghist_o  out  ghist_width_p  ghist snapshot at lookup time, for restore.
spec_v_i  in  1  shift a speculative outcome into ghist.
spec_taken_i  in  1  speculative direction.
restore_v_i  in  1  overwrite ghist (misprediction redirect).
restore_ghist_i  in  ghist_width_p  history to load.
w_v_i  in  1  train request.
w_idx_i  in  bht_idx_width_p  hashed index to train.
w_taken_i  in  1  resolved direction.

Behaviour:
- Reset (async assert): ghist=0, state=CLEAR, clear pointer=0, init_done_o=0, predict_v_o=0, predict_taken_o=0, predict_idx_o=0, predict_ghist_o=0. Table contents are not reset asynchronously.
- FSM CLEAR: each enabled cycle writes WNT=2**(ctr_width_p-1)-1 (01 for 2-bit) to entry[ptr] and increments ptr. After writing entry 2**bht_idx_width_p-1, the FSM enters READY and init_done_o rises the next cycle. Sweep length is exactly 2**bht_idx_width_p enabled cycles.
- In CLEAR: r_v_i, w_v_i, spec_v_i and restore_v_i are ignored, and predict_v_o stays 0.
- FSM READY is terminal until reset.
- Hash: h = r_idx_i XOR zero-extended ghist (ghist aligned to the LSBs).
- Read: on an accepted r_v_i in cycle t, the outputs in cycle t+1 are:
  - predict_v_o=1;
  - predict_taken_o=entry[h][ctr_width_p-1];
  - predict_idx_o=h;
  - predict_ghist_o=the ghist value at cycle t.
- Without r_v_i, predict_v_o=0 next cycle and the other prediction outputs hold.
- Train: on w_v_i, entry[w_idx_i] is incremented if w_taken_i and decremented otherwise. Counters saturate at 2**ctr_width_p-1 and at 0. The update commits at the clock edge.
- Read and write in the same cycle, same index: the read returns the pre-update value. Writes are never lost.
- ghist update priority is restore over spec:
  - restore_v_i: ghist <= restore_ghist_i, and spec_v_i in the same cycle is dropped;
  - else spec_v_i: ghist <= {ghist[ghist_width_p-2:0], spec_taken_i} (for width 1, ghist <= spec_taken_i).
- Ordering within a cycle: a lookup in cycle t hashes with the pre-update ghist. A spec or restore in cycle t affects lookups from t+1.
- en_i=0: no table write, no ghist change, no pointer advance; predict_* outputs hold their values, including predict_v_o.
- Reset mid-sweep or mid-operation restarts CLEAR from entry 0. Any in-flight prediction output is cleared.

Test Plan:
- Clear sweep: bht_idx_width_p=4, release reset, hold en_i=1. init_done_o must rise after exactly 16 cycles. Then r_v_i at every idx with ghist=0 gives predict_taken_o=0, and a backdoor read shows every entry=2'b01.
- Saturation: w_v_i idx 5 with taken for 4 cycles gives entry 11 and predict_taken_o=1. Then not-taken 2 cycles gives 01 and predict_taken_o=0. Then 3 more not-taken gives 00 (no wrap).
- Hash and history: spec_v_i taken 3 times gives ghist=0x07. Then r_v_i idx 0x0F gives predict_idx_o=0x08 and predict_ghist_o=0x07.
- Restore priority: spec_v_i=1 and restore_v_i=1 with restore_ghist_i=0xA5 in the same cycle gives ghist=0xA5 (no shift). A read next cycle with idx 0 gives predict_idx_o=0x0A5.
- Same-cycle read/write: entry 3=01, r_v_i idx 3 and w_v_i idx 3 taken in the same cycle gives predict_taken_o=0 next cycle. A following read gives 1.
- en_i and reset: deassert en_i mid-sweep for 5 cycles and check the sweep completes 5 cycles later. Assert reset_n_i low mid-READY and check init_done_o=0 and predict_v_o=0 immediately (async) and the sweep restarts at 0.

Source files
------------

// File: rtl/bp_fe_bht_gshare.sv
// Gshare branch history table: registered lookup hashed with speculative global history,
// post-reset clear sweep, saturating-counter training and history restore on redirect.
module bp_fe_bht_gshare #(
   parameter int bht_idx_width_p = 9,
   parameter int ghist_width_p   = 8,
   parameter int ctr_width_p     = 2
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       en_i,
   output logic                       init_done_o,
   input  logic                       r_v_i,
   input  logic [bht_idx_width_p-1:0] r_idx_i,
   output logic                       predict_v_o,
   output logic                       predict_taken_o,
   output logic [bht_idx_width_p-1:0] predict_idx_o,
   output logic [ghist_width_p-1:0]   predict_ghist_o,
   input  logic                       spec_v_i,
   input  logic                       spec_taken_i,
   input  logic                       restore_v_i,
   input  logic [ghist_width_p-1:0]   restore_ghist_i,
   input  logic                       w_v_i,
   input  logic [bht_idx_width_p-1:0] w_idx_i,
   input  logic                       w_taken_i
);

   localparam int entries_lp = 2 ** bht_idx_width_p;
   localparam logic [ctr_width_p-1:0] ctr_wnt_lp  = {1'b0, {(ctr_width_p-1){1'b1}}};
   localparam logic [ctr_width_p-1:0] ctr_max_lp  = {ctr_width_p{1'b1}};
   localparam logic [ctr_width_p-1:0] ctr_zero_lp = {ctr_width_p{1'b0}};
   localparam logic [ctr_width_p-1:0] ctr_one_lp  = {{(ctr_width_p-1){1'b0}}, 1'b1};
   localparam logic [bht_idx_width_p-1:0] ptr_last_lp = {bht_idx_width_p{1'b1}};
   localparam logic [bht_idx_width_p-1:0] ptr_one_lp  = {{(bht_idx_width_p-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

   // Saturating up/down counter step.
   function automatic logic [ctr_width_p-1:0] ctr_next(input logic [ctr_width_p-1:0] ctr,
                                                       input logic                   taken);
      logic [ctr_width_p-1:0] res;
      if (taken) begin
         res = (ctr == ctr_max_lp) ? ctr : ctr + ctr_one_lp;
      end else begin
         res = (ctr == ctr_zero_lp) ? ctr : ctr - ctr_one_lp;
      end
      return res;
   endfunction

   logic [ctr_width_p-1:0]     mem_r [entries_lp];
   state_e                     state_r, state_n;
   logic [bht_idx_width_p-1:0] clr_ptr_r, clr_ptr_n;
   logic                       clr_we_s;
   logic                       done_set_s;
   logic                       init_done_r;
   logic [ghist_width_p-1:0]   ghist_r;
   logic [ghist_width_p-1:0]   ghist_shift_s;
   logic [bht_idx_width_p-1:0] ghist_ext_s;
   logic [bht_idx_width_p-1:0] hash_s;
   logic                       ready_s;
   logic                       rd_acc_s;
   logic                       wr_acc_s;
   logic                       predict_v_r;
   logic                       predict_taken_r;
   logic [bht_idx_width_p-1:0] predict_idx_r;
   logic [ghist_width_p-1:0]   predict_ghist_r;

   assign ready_s  = (state_r == ST_READY);
   assign rd_acc_s = en_i & ready_s & r_v_i;
   assign wr_acc_s = en_i & ready_s & w_v_i;

   if (ghist_width_p == 1) begin : g_ghist_one
      assign ghist_shift_s = spec_taken_i;
   end else begin : g_ghist_multi
      assign ghist_shift_s = {ghist_r[ghist_width_p-2:0], spec_taken_i};
   end

   // History is zero-extended and aligned to the index LSBs before hashing.
   always_comb begin
      ghist_ext_s = {bht_idx_width_p{1'b0}};
      ghist_ext_s[ghist_width_p-1:0] = ghist_r;
      hash_s = r_idx_i ^ ghist_ext_s;
   end

   // Clear-sweep FSM next-state logic; READY is terminal until reset.
   always_comb begin
      state_n    = state_r;
      clr_ptr_n  = clr_ptr_r;
      clr_we_s   = 1'b0;
      done_set_s = 1'b0;
      case (state_r)
         ST_CLEAR: begin
            if (en_i) begin
               clr_we_s  = 1'b1;
               clr_ptr_n = clr_ptr_r + ptr_one_lp;
               if (clr_ptr_r == ptr_last_lp) begin
                  state_n    = ST_READY;
                  done_set_s = 1'b1;
               end else begin
                  state_n = ST_CLEAR;
               end
            end else begin
               clr_ptr_n = clr_ptr_r;
            end
         end
         ST_READY: begin
            state_n = ST_READY;
         end
         default: begin
            state_n = ST_CLEAR;
         end
      endcase
   end

   // FSM state, clear pointer and completion flag.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r     <= ST_CLEAR;
         clr_ptr_r   <= {bht_idx_width_p{1'b0}};
         init_done_r <= 1'b0;
      end else begin
         state_r   <= state_n;
         clr_ptr_r <= clr_ptr_n;
         if (done_set_s) begin
            init_done_r <= 1'b1;
         end
      end
   end

   // Counter table: the sweep owns the write port in CLEAR, training owns it in READY.
   always_ff @(posedge clk_i) begin
      if (clr_we_s) begin
         mem_r[clr_ptr_r] <= ctr_wnt_lp;
      end else if (wr_acc_s) begin
         mem_r[w_idx_i] <= ctr_next(mem_r[w_idx_i], w_taken_i);
      end
   end

   // Speculative global history; a restore wins over a same-cycle speculative shift.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         ghist_r <= {ghist_width_p{1'b0}};
      end else if (en_i && ready_s) begin
         if (restore_v_i) begin
            ghist_r <= restore_ghist_i;
         end else if (spec_v_i) begin
            ghist_r <= ghist_shift_s;
         end
      end
   end

   // Registered prediction; the table read sees the value before any same-edge training.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         predict_v_r     <= 1'b0;
         predict_taken_r <= 1'b0;
         predict_idx_r   <= {bht_idx_width_p{1'b0}};
         predict_ghist_r <= {ghist_width_p{1'b0}};
      end else if (en_i) begin
         predict_v_r <= rd_acc_s;
         if (rd_acc_s) begin
            predict_taken_r <= mem_r[hash_s][ctr_width_p-1];
            predict_idx_r   <= hash_s;
            predict_ghist_r <= ghist_r;
         end
      end
   end

   assign init_done_o     = init_done_r;
   assign predict_v_o     = predict_v_r;
   assign predict_taken_o = predict_taken_r;
   assign predict_idx_o   = predict_idx_r;
   assign predict_ghist_o = predict_ghist_r;

endmodule
